// File: rtl/lpm_tcam_pkg.sv
// Shared constants and helpers for the longest-prefix-match TCAM.
// The forwarding engine imports the same package for the miss encoding.
package lpm_tcam_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int ENTRIES_DEF = 16;
  localparam int IF_W_DEF    = 4;

  // A miss reports zero in every result field
  localparam logic MISS_HIT = 1'b0;
  localparam int   MISS_VAL = 0;

  function automatic int plen_width(input int aw);
    return $clog2(aw + 1);
  endfunction

endpackage

// File: rtl/lpm_tcam_popcount.sv
// Population count of a route mask, giving the stored prefix length.
// Non-contiguous masks simply count their set bits.
module lpm_popcount #(
  parameter int W  = 32,
  parameter int OW = 6
) (
  input  logic [W-1:0]  bits_i,
  output logic [OW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + OW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/lpm_tcam.sv
// Longest-prefix-match TCAM: flop-array route table, single write port,
// three-stage lookup pipeline (match, select, output register).
module lpm_tcam
  import lpm_tcam_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IF_W    = IF_W_DEF,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int PLEN_W  = plen_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_prefix,
  input  logic [ADDR_W-1:0] wr_mask,
  input  logic [IF_W-1:0]   wr_if,
  input  logic [ADDR_W-1:0] wr_nexthop,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              res_valid,
  output logic              res_hit,
  output logic [IF_W-1:0]   res_if,
  output logic [ADDR_W-1:0] res_nexthop,
  output logic [PLEN_W-1:0] res_plen,
  output logic [IDX_W-1:0]  res_idx
);

  localparam logic [IDX_W:0] ENTRY_LIM = (IDX_W + 1)'(ENTRIES);

  // Route table
  logic [ADDR_W-1:0] pfx_q  [ENTRIES];
  logic [ADDR_W-1:0] msk_q  [ENTRIES];
  logic [ADDR_W-1:0] nh_q   [ENTRIES];
  logic [IF_W-1:0]   if_q   [ENTRIES];
  logic [PLEN_W-1:0] plen_q [ENTRIES];
  logic [ENTRIES-1:0] vld_q;

  logic [PLEN_W-1:0] wr_plen;
  logic              wr_ok;

  lpm_popcount #(
    .W  (ADDR_W),
    .OW (PLEN_W)
  ) u_popcount (
    .bits_i (wr_mask),
    .cnt_o  (wr_plen)
  );

  assign wr_ok = wr_en && ({1'b0, wr_idx} < ENTRY_LIM);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      pfx_q[wr_idx]  <= wr_prefix & wr_mask;
      msk_q[wr_idx]  <= wr_mask;
      nh_q[wr_idx]   <= wr_nexthop;
      if_q[wr_idx]   <= wr_if;
      plen_q[wr_idx] <= wr_plen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (wr_ok) begin
      vld_q[wr_idx] <= wr_valid;
    end
  end

  // S1: match, snapshotting the per-entry payload so later writes
  // cannot leak into an in-flight lookup
  logic [ENTRIES-1:0] match_d;
  logic               s1_v_q;
  logic [ENTRIES-1:0] s1_m_q;
  logic [PLEN_W-1:0]  s1_plen_q [ENTRIES];
  logic [IF_W-1:0]    s1_if_q   [ENTRIES];
  logic [ADDR_W-1:0]  s1_nh_q   [ENTRIES];

  always_comb begin
    match_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_d[i] = vld_q[i] &&
                   (((lk_addr & msk_q[i]) ^ pfx_q[i]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
    end else begin
      s1_v_q <= lk_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_m_q <= match_d;
    for (int i = 0; i < ENTRIES; i++) begin
      s1_plen_q[i] <= plen_q[i];
      s1_if_q[i]   <= if_q[i];
      s1_nh_q[i]   <= nh_q[i];
    end
  end

  // S2: longest plen wins; strict compare keeps the lowest index on ties
  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic [PLEN_W-1:0] win_plen;

  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_plen = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (s1_m_q[i] && (!win_hit || s1_plen_q[i] > win_plen)) begin
        win_hit  = 1'b1;
        win_idx  = IDX_W'(i);
        win_plen = s1_plen_q[i];
      end
    end
  end

  logic              s2_v_q;
  logic              s2_hit_d,  s2_hit_q;
  logic [IF_W-1:0]   s2_if_d,   s2_if_q;
  logic [ADDR_W-1:0] s2_nh_d,   s2_nh_q;
  logic [PLEN_W-1:0] s2_plen_d, s2_plen_q;
  logic [IDX_W-1:0]  s2_idx_d,  s2_idx_q;

  always_comb begin
    s2_hit_d  = MISS_HIT;
    s2_if_d   = IF_W'(MISS_VAL);
    s2_nh_d   = ADDR_W'(MISS_VAL);
    s2_plen_d = PLEN_W'(MISS_VAL);
    s2_idx_d  = IDX_W'(MISS_VAL);
    if (win_hit) begin
      s2_hit_d  = 1'b1;
      s2_if_d   = s1_if_q[win_idx];
      s2_nh_d   = s1_nh_q[win_idx];
      s2_plen_d = win_plen;
      s2_idx_d  = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
    end else begin
      s2_v_q <= s1_v_q;
    end
  end

  always_ff @(posedge clk) begin
    s2_hit_q  <= s2_hit_d;
    s2_if_q   <= s2_if_d;
    s2_nh_q   <= s2_nh_d;
    s2_plen_q <= s2_plen_d;
    s2_idx_q  <= s2_idx_d;
  end

  // S3: output register; fields hold while no result is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_if      <= '0;
      res_nexthop <= '0;
      res_plen    <= '0;
      res_idx     <= '0;
    end else begin
      res_valid <= s2_v_q;
      if (s2_v_q) begin
        res_hit     <= s2_hit_q;
        res_if      <= s2_if_q;
        res_nexthop <= s2_nh_q;
        res_plen    <= s2_plen_q;
        res_idx     <= s2_idx_q;
      end
    end
  end

endmodule

// File: tb/tb_lpm_tcam.sv
// Directed bench for lpm_tcam: reset, LPM selection, ties, default
// route, delete/lookup ordering, streaming and mid-stream reset.
module tb_lpm_tcam;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        wr_valid;
  logic [31:0] wr_prefix;
  logic [31:0] wr_mask;
  logic [3:0]  wr_if;
  logic [31:0] wr_nexthop;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        res_valid;
  logic        res_hit;
  logic [3:0]  res_if;
  logic [31:0] res_nexthop;
  logic [5:0]  res_plen;
  logic [3:0]  res_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lpm_tcam dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_valid    (wr_valid),
    .wr_prefix   (wr_prefix),
    .wr_mask     (wr_mask),
    .wr_if       (wr_if),
    .wr_nexthop  (wr_nexthop),
    .lk_valid    (lk_valid),
    .lk_addr     (lk_addr),
    .res_valid   (res_valid),
    .res_hit     (res_hit),
    .res_if      (res_if),
    .res_nexthop (res_nexthop),
    .res_plen    (res_plen),
    .res_idx     (res_idx)
  );

  // {hit, if, nexthop, plen, idx}
  logic [46:0] got;
  assign got = {res_hit, res_if, res_nexthop, res_plen, res_idx};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic v, input logic [31:0] p,
                    input logic [31:0] m, input logic [3:0] ifx,
                    input logic [31:0] nh);
    wr_en      = 1'b1;
    wr_idx     = idx[3:0];
    wr_valid   = v;
    wr_prefix  = p;
    wr_mask    = m;
    wr_if      = ifx;
    wr_nexthop = nh;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a);
    lk_valid = 1'b1;
    lk_addr  = a;
    tick();
    lk_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [46:0] exp;
    rst = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", res_valid);
    end
    checks++;
    if (got !== 47'h0) begin
      failures++;
      $display("FAIL reset_fields got=%h exp=0", got);
    end
    rst = 1'b0;
    tick();
    lk_valid = 1'b1;
    lk_addr  = 32'hC0A80001;
    tick();
    lk_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_valid got=%b exp=0", res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL miss_valid got=%b exp=1", res_valid);
    end
    exp = 47'h0;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL miss_fields got=%h exp=%h", got, exp);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_strobe got=%b exp=0", res_valid);
    end
  endtask

  task automatic test_longest();
    wr(0, 1'b1, 32'hC0A80000, 32'hFFFF0000, 4'd1, 32'h0A000001);
    // host bits set to exercise pre-masking
    wr(1, 1'b1, 32'hC0A800AB, 32'hFFFFFF00, 4'd2, 32'h0A000002);
    lookup(32'hC0A80005);
    checks++;
    if (res_valid !== 1'b1 ||
        got !== {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1}) begin
      failures++;
      $display("FAIL lpm_24 got=%h v=%b exp=%h", got, res_valid,
               {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1});
    end
    lookup(32'hC0A80105);
    checks++;
    if (res_valid !== 1'b1 ||
        got !== {1'b1, 4'd1, 32'h0A000001, 6'd16, 4'd0}) begin
      failures++;
      $display("FAIL lpm_16 got=%h v=%b exp=%h", got, res_valid,
               {1'b1, 4'd1, 32'h0A000001, 6'd16, 4'd0});
    end
  endtask

  task automatic test_tie();
    wr(5, 1'b1, 32'h0A000000, 32'hFF000000, 4'd5, 32'h0A0A0A05);
    wr(3, 1'b1, 32'h0A000000, 32'hFF000000, 4'd4, 32'h0A0A0A03);
    lookup(32'h0A010203);
    checks++;
    if (got !== {1'b1, 4'd4, 32'h0A0A0A03, 6'd8, 4'd3}) begin
      failures++;
      $display("FAIL tie_low_idx got=%h exp=%h", got,
               {1'b1, 4'd4, 32'h0A0A0A03, 6'd8, 4'd3});
    end
  endtask

  task automatic test_default();
    wr(7, 1'b1, 32'h12345678, 32'h00000000, 4'd3, 32'h01020304);
    lookup(32'h08080808);
    checks++;
    if (got !== {1'b1, 4'd3, 32'h01020304, 6'd0, 4'd7}) begin
      failures++;
      $display("FAIL default_route got=%h exp=%h", got,
               {1'b1, 4'd3, 32'h01020304, 6'd0, 4'd7});
    end
    lookup(32'hC0A80005);
    checks++;
    if (got !== {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1}) begin
      failures++;
      $display("FAIL default_loses got=%h exp=%h", got,
               {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1});
    end
    // non-contiguous mask: plen is the popcount (2)
    wr(9, 1'b1, 32'h80000001, 32'h80000001, 4'd9, 32'h09090909);
    lookup(32'h8F0000F1);
    checks++;
    if (got !== {1'b1, 4'd9, 32'h09090909, 6'd2, 4'd9}) begin
      failures++;
      $display("FAIL noncontig got=%h exp=%h", got,
               {1'b1, 4'd9, 32'h09090909, 6'd2, 4'd9});
    end
    wr(9, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0);
  endtask

  task automatic test_delete_same_cycle();
    wr_en    = 1'b1;
    wr_idx   = 4'd1;
    wr_valid = 1'b0;
    lk_valid = 1'b1;
    lk_addr  = 32'hC0A80005;
    tick();
    wr_en = 1'b0;
    tick();
    lk_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 ||
        got !== {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1}) begin
      failures++;
      $display("FAIL del_old_table got=%h v=%b exp=%h", got, res_valid,
               {1'b1, 4'd2, 32'h0A000002, 6'd24, 4'd1});
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 ||
        got !== {1'b1, 4'd1, 32'h0A000001, 6'd16, 4'd0}) begin
      failures++;
      $display("FAIL del_new_table got=%h v=%b exp=%h", got, res_valid,
               {1'b1, 4'd1, 32'h0A000001, 6'd16, 4'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [46:0] exp;
    int bad = 0;
    wr(2, 1'b1, 32'hC0A80100, 32'hFFFFFF00, 4'd6, 32'h0A000006);
    for (int j = 0; j < 302; j++) begin
      lk_valid = (j < 300);
      lk_addr  = 32'hC0A80001 + 32'(j);
      tick();
      if (j >= 2) begin
        a = 32'hC0A80001 + 32'(j - 2);
        if (a[15:8] == 8'h01)
          exp = {1'b1, 4'd6, 32'h0A000006, 6'd24, 4'd2};
        else
          exp = {1'b1, 4'd1, 32'h0A000001, 6'd16, 4'd0};
        checks++;
        if (res_valid !== 1'b1 || got !== exp) begin
          failures++;
          bad++;
          if (bad < 5)
            $display("FAIL stream[%0d] got=%h v=%b exp=%h", j - 2, got,
                     res_valid, exp);
        end
      end
    end
    lk_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_tail got=%b exp=0", res_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      lk_valid = 1'b1;
      lk_addr  = 32'hC0A80010 + 32'(j);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_valid got=%b exp=0", res_valid);
    end
    lk_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale_result got=%b exp=0", seen);
    end
    lookup(32'h08080808);
    checks++;
    if (res_valid !== 1'b1 || got !== 47'h0) begin
      failures++;
      $display("FAIL rst_table_empty got=%h v=%b exp=0", got, res_valid);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_valid   = 1'b0;
    wr_prefix  = '0;
    wr_mask    = '0;
    wr_if      = '0;
    wr_nexthop = '0;
    lk_valid   = 1'b0;
    lk_addr    = '0;
    test_reset();
    test_longest();
    test_tie();
    test_default();
    test_delete_same_cycle();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
